// File: rtl/mips_cpu_bus_bridge.sv
// Serialises MIPS fetch and data requests onto one Avalon-MM master port.
// Define BUS_TIMEOUT_EN to abort accesses stalled for TIMEOUT_CYCLES.
module mips_cpu_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        busy,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    IDLE,
    D_ACC,
    I_ACC,
    RESP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        in_acc;
  logic        abort;
  logic [31:0] cap;

  logic        i_done_n;
  logic        d_done_n;
  logic        busy_n;
  logic [31:0] i_rdata_n;
  logic [31:0] d_rdata_n;
  logic [31:0] addr_n;
  logic [31:0] wdata_n;
  logic [3:0]  be_n;
  logic        rd_n;
  logic        wr_n;
  logic        err_n;

  assign in_acc = (state == D_ACC) || (state == I_ACC);

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset || !in_acc) begin
      stall_cnt <= '0;
    end else if (avm_waitrequest) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end

  // Fires on the last tolerated stall cycle
  assign abort = in_acc && avm_waitrequest &&
                 (stall_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign cap   = avm_waitrequest ? 32'hDEADBEEF : avm_readdata;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort = 1'b0;
  assign cap   = avm_readdata;
`endif

  always_comb begin
    state_n   = state;
    addr_n    = avm_address;
    wdata_n   = avm_writedata;
    be_n      = avm_byteenable;
    rd_n      = avm_read;
    wr_n      = avm_write;
    i_rdata_n = i_rdata;
    d_rdata_n = d_rdata;
    i_done_n  = 1'b0;
    d_done_n  = 1'b0;
    err_n     = bus_error | abort;
    unique case (state)
      IDLE: begin
        if (d_req) begin
          addr_n  = {d_addr[31:2], 2'b00};
          wdata_n = d_wdata;
          be_n    = d_we ? d_be : 4'hF;
          if (d_we && (d_be == 4'h0)) begin
            // nothing to store: complete without a bus cycle
            state_n  = RESP;
            d_done_n = 1'b1;
          end else begin
            state_n = D_ACC;
            rd_n    = !d_we;
            wr_n    = d_we;
          end
        end else if (i_req) begin
          addr_n  = {i_addr[31:2], 2'b00};
          be_n    = 4'hF;
          rd_n    = 1'b1;
          state_n = I_ACC;
        end
      end
      D_ACC, I_ACC: begin
        if (!avm_waitrequest || abort) begin
          state_n = RESP;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          if (state == D_ACC) begin
            d_done_n = 1'b1;
            if (avm_read) begin
              d_rdata_n = cap;
            end
          end else begin
            i_done_n  = 1'b1;
            i_rdata_n = cap;
          end
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy_n = (state_n != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      i_done         <= 1'b0;
      d_done         <= 1'b0;
      busy           <= 1'b0;
      i_rdata        <= '0;
      d_rdata        <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      bus_error      <= 1'b0;
    end else begin
      state          <= state_n;
      i_done         <= i_done_n;
      d_done         <= d_done_n;
      busy           <= busy_n;
      i_rdata        <= i_rdata_n;
      d_rdata        <= d_rdata_n;
      avm_address    <= addr_n;
      avm_read       <= rd_n;
      avm_write      <= wr_n;
      avm_writedata  <= wdata_n;
      avm_byteenable <= be_n;
      bus_error      <= err_n;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_bridge.sv
// Self-checking bench for mips_cpu_bus_bridge: vector table, corner
// sequences and random traffic against a latency/rdata reference model.
module tb_mips_cpu_bus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        busy;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        bus_error;

  mips_cpu_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_done(i_done),
    .i_rdata(i_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_be(d_be),
    .d_wdata(d_wdata),
    .d_done(d_done),
    .d_rdata(d_rdata),
    .busy(busy),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dq;
    bit          iq;
    bit          we;
    bit          drop;
    logic [31:0] da;
    logic [31:0] ia;
    logic [31:0] wd;
    logic [31:0] drd;
    logic [31:0] ird;
    logic [3:0]  be;
    int          wdn;
    int          win;
    logic [31:0] e_da;
    logic [31:0] e_ia;
    int          e_dd;
    int          e_id;
    int          e_dc;
    int          e_ic;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_i;
  logic [31:0] m_d;
  logic        m_err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    bit dq, bit we, logic [31:0] da, logic [3:0] be,
    logic [31:0] wd, int wdn, logic [31:0] drd,
    logic [31:0] e_da, int e_dd, int e_dc,
    bit iq, logic [31:0] ia, int win, logic [31:0] ird,
    logic [31:0] e_ia, int e_id, int e_ic, bit drop);
    vec_t v;
    v.dq = dq;   v.we = we;   v.da = da;    v.be = be;
    v.wd = wd;   v.wdn = wdn; v.drd = drd;
    v.e_da = e_da; v.e_dd = e_dd; v.e_dc = e_dc;
    v.iq = iq;   v.ia = ia;   v.win = win;  v.ird = ird;
    v.e_ia = e_ia; v.e_id = e_id; v.e_ic = e_ic;
    v.drop = drop;
    return v;
  endfunction

  // Plays requester and slave for one transaction set; model already updated
  task automatic xact(input vec_t v);
    int  c;
    int  dc;
    int  ic;
    int  dd_at;
    int  id_at;
    int  ddn;
    int  idn;
    bit  d_pend;
    bit  i_pend;
    bit  wt;
    d_req = v.dq; d_we = v.we; d_addr = v.da;
    d_be = v.be;  d_wdata = v.wd;
    i_req = v.iq; i_addr = v.ia;
    d_pend = v.dq; i_pend = v.iq;
    c = 0; dc = 0; ic = 0; ddn = 0; idn = 0;
    dd_at = -1; id_at = -1;
    while ((d_pend || i_pend) && c < 100) begin
      step();
      c++;
      if (c >= 1 && d_pend) begin
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = 4'($urandom);
        d_we    = 1'($urandom);
        if (v.drop) d_req = 1'b0;
      end
      if (c >= 1 && !v.dq) i_addr = $urandom;
      if (d_done) begin
        ddn++;
        if (dd_at < 0) dd_at = c;
        chk("d_rdata_at_done", d_rdata, m_d);
        d_pend = 1'b0;
        d_req  = 1'b0;
      end
      if (i_done) begin
        idn++;
        if (id_at < 0) id_at = c;
        chk("i_rdata_at_done", i_rdata, m_i);
        i_pend = 1'b0;
        i_req  = 1'b0;
      end
      if (avm_read || avm_write || d_done || i_done)
        chk("busy_active", 32'(busy), 1);
      if (avm_read || avm_write) begin
        wt = 1'b0;
        if (d_pend) begin
          chk("d_addr", avm_address, v.e_da);
          chk("d_cmd", {avm_read, avm_write}, v.we ? 2'b01 : 2'b10);
          chk("d_be", avm_byteenable, v.we ? v.be : 4'hF);
          if (v.we) chk("d_wdata", avm_writedata, v.wd);
          wt = dc < v.wdn;
          dc++;
          avm_readdata = wt ? $urandom : v.drd;
        end else begin
          chk("i_addr", avm_address, v.e_ia);
          chk("i_cmd", {avm_read, avm_write}, 2'b10);
          chk("i_be", avm_byteenable, 4'hF);
          wt = ic < v.win;
          ic++;
          avm_readdata = wt ? $urandom : v.ird;
        end
        avm_waitrequest = wt;
      end else begin
        avm_waitrequest = 1'($urandom);
        avm_readdata    = $urandom;
      end
    end
    if (d_pend || i_pend) begin
      n_cmp++;
      n_err++;
      $display("FAIL xact_budget: got pending %0d%0d want 00",
               d_pend, i_pend);
      d_req = 1'b0;
      i_req = 1'b0;
    end
    chk("d_done_cnt", ddn, v.dq ? 1 : 0);
    chk("i_done_cnt", idn, v.iq ? 1 : 0);
    if (v.dq) begin
      chk("d_done_cycle", dd_at, v.e_dd);
      chk("d_cmd_cycles", dc, v.e_dc);
    end
    if (v.iq) begin
      chk("i_done_cycle", id_at, v.e_id);
      chk("i_cmd_cycles", ic, v.e_ic);
    end
    step();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cmd", {avm_read, avm_write, d_done, i_done}, 4'h0);
    chk("i_rdata", i_rdata, m_i);
    chk("d_rdata", d_rdata, m_d);
    chk("bus_error", 32'(bus_error), 32'(m_err));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    m_i = '0;
    m_d = '0;
    m_err = 1'b0;
  endtask

  task automatic model_update(input vec_t v);
    if (v.dq && !v.we) m_d = v.drd;
    if (v.iq) m_i = v.ird;
  endtask

  vec_t tbl[6];
  vec_t v;

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_be = '0; d_wdata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0;

    tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                1, 32'hBFC00003, 0, 32'h24020005,
                32'hBFC00000, 2, 1, 0);
    tbl[1] = mk(1, 1, 32'h1004, 4'b0011, 32'hAABBCCDD, 3, 0,
                32'h1004, 5, 4,
                0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(1, 0, 32'h2000, 4'h0, 0, 0, 32'h11112222,
                32'h2000, 2, 1,
                1, 32'h400, 0, 32'h33334444, 32'h400, 5, 1, 0);
    tbl[3] = mk(1, 1, 32'h3000, 4'h0, 32'h5555AAAA, 0, 0,
                32'h3000, 1, 0,
                0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(1, 0, 32'h77, 4'h0, 0, 2, 32'hCAFEF00D,
                32'h74, 4, 3,
                0, 0, 0, 0, 0, 0, 0, 1);
    tbl[5] = mk(1, 1, 32'h8006, 4'hF, 32'h01234567, 1, 0,
                32'h8004, 3, 2,
                1, 32'h9001, 2, 32'h89ABCDEF, 32'h9000, 8, 3, 0);

    apply_reset();
    chk("rst_i_done", 32'(i_done), 0);
    chk("rst_d_done", 32'(d_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd", {avm_read, avm_write}, 2'b00);
    chk("rst_addr", avm_address, 0);
    chk("rst_be", 32'(avm_byteenable), 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_bus_error", 32'(bus_error), 0);

    for (int k = 0; k < 6; k++) begin
      model_update(tbl[k]);
      xact(tbl[k]);
    end

    // reset while a read is stalled
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    avm_waitrequest = 1'b1;
    step();
    chk("rst_mid_pre", 32'(avm_read), 1);
    reset = 1'b1;
    d_req = 1'b0;
    step();
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    m_i = '0; m_d = '0; m_err = 1'b0;
    chk("rst_mid_read", 32'(avm_read), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(d_done), 0);
    chk("rst_mid_d_rdata", d_rdata, 0);
    chk("rst_mid_i_rdata", i_rdata, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_mid_quiet", {avm_read, d_done, busy}, 3'b000);
    end

`ifdef BUS_TIMEOUT_EN
    v = mk(1, 0, 32'h500, 4'h0, 0, 1000, 32'h12345678,
           32'h500, 1 + TO, TO, 0, 0, 0, 0, 0, 0, 0, 0);
    m_d = 32'hDEADBEEF;
    m_err = 1'b1;
    xact(v);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
           1, 32'h40, 1, 32'h0BADF00D, 32'h40, 3, 2, 0);
    model_update(v);
    xact(v);
    apply_reset();
    chk("to_err_cleared", 32'(bus_error), 0);
`else
    v = mk(1, 0, 32'h500, 4'h0, 0, 20, 32'h12345678,
           32'h500, 22, 21, 0, 0, 0, 0, 0, 0, 0, 0);
    model_update(v);
    xact(v);
`endif

    for (int k = 0; k < 40; k++) begin
      int  r;
      int  td;
      bit  be0;
      r     = $urandom_range(1, 3);
      v.dq  = r[0];
      v.iq  = r[1];
      v.we  = 1'($urandom);
      v.drop = ($urandom_range(0, 3) == 0);
      v.da  = $urandom;
      v.ia  = $urandom;
      v.wd  = $urandom;
      v.drd = $urandom;
      v.ird = $urandom;
      v.be  = ($urandom_range(0, 3) == 0) ? 4'h0
                                          : 4'($urandom_range(1, 15));
      v.wdn = $urandom_range(0, 3);
      v.win = $urandom_range(0, 3);
      be0    = v.we && (v.be == 4'h0);
      td     = be0 ? 1 : 2 + v.wdn;
      v.e_da = v.da & ~32'h3;
      v.e_ia = v.ia & ~32'h3;
      v.e_dd = td;
      v.e_dc = be0 ? 0 : v.wdn + 1;
      v.e_id = v.dq ? td + 3 + v.win : 2 + v.win;
      v.e_ic = v.win + 1;
      model_update(v);
      xact(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
